// File: rtl/spectro_pkg.sv
// Shared widths, tags, sync pattern and state encoding for the spectrometer frame packer.
package spectro_pkg;

  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CNT_W    = 16;

  localparam logic [1:0]       TAG_DATA  = 2'b01;
  localparam logic [1:0]       TAG_LAST  = 2'b11;
  localparam logic [CNT_W-1:0] SYNC_WORD = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PACK
  } state_e;

  // Packed data word: tag on top, three samples with slot0 in the low bits.
  typedef struct packed {
    logic [1:0]          tag;
    logic [SAMPLE_W-1:0] s2;
    logic [SAMPLE_W-1:0] s1;
    logic [SAMPLE_W-1:0] s0;
  } pack_word_t;

endpackage

// File: rtl/spectro_word_fifo.sv
// First-word-fall-through word FIFO; a push into a full FIFO is accepted only alongside a pop.
module spectro_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spectro_frame_packer.sv
// Groups 10-bit samples into header-prefixed frames, three samples per 32-bit word,
// buffered in a small FWFT FIFO; overflow is flagged since upstream cannot stall.
module spectro_frame_packer
  import spectro_pkg::*;
#(
  parameter int unsigned PIXELS_PER_FRAME = 2048,
  parameter int unsigned OUT_DEPTH        = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] sampleIn,
  input  logic                sampleValid,
  input  logic                armEn,
  output logic [WORD_W-1:0]   wordOut,
  output logic                wordValid,
  input  logic                wordReady,
  output logic                frameDone,
  output logic [CNT_W-1:0]    frameCount,
  output logic                overflow
);

  state_e                       state_q;
  logic [1:0]                   slot_q;
  logic [CNT_W-1:0]             pix_q;
  logic [2:0][SAMPLE_W-1:0]     slots_q;
  logic                         frame_done_q;
  logic [CNT_W-1:0]             frame_count_q;
  logic                         overflow_q;

  logic [2:0][SAMPLE_W-1:0]     slots_c;
  logic [CNT_W-1:0]             pix_inc_c;
  logic                         last_c;
  logic                         word_full_c;
  logic                         push_c;
  pack_word_t                   pack_c;
  logic [WORD_W-1:0]            push_word_c;
  logic                         fifo_full;
  logic                         fifo_empty;

  // Word under construction with the current sample dropped into its slot.
  always_comb begin
    slots_c = slots_q;
    case (slot_q)
      2'd0:    slots_c[0] = sampleIn;
      2'd1:    slots_c[1] = sampleIn;
      default: slots_c[2] = sampleIn;
    endcase
    pix_inc_c   = pix_q + CNT_W'(1);
    last_c      = (state_q == PACK) & sampleValid & (pix_inc_c == CNT_W'(PIXELS_PER_FRAME));
    word_full_c = (state_q == PACK) & sampleValid & (slot_q == 2'd2);
    push_c      = (state_q == HDR) | last_c | word_full_c;
    pack_c.tag  = last_c ? TAG_LAST : TAG_DATA;
    pack_c.s2   = slots_c[2];
    pack_c.s1   = slots_c[1];
    pack_c.s0   = slots_c[0];
    push_word_c = (state_q == HDR) ? {SYNC_WORD, frame_count_q} : WORD_W'(pack_c);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      slot_q        <= 2'd0;
      pix_q         <= '0;
      slots_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // A full FIFO only takes the word when the head leaves in the same cycle.
      if (push_c & fifo_full & ~wordReady) overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (armEn) state_q <= HDR;
        HDR:  state_q <= PACK;
        PACK: begin
          if (sampleValid) begin
            if (last_c) begin
              slots_q       <= '0;
              slot_q        <= 2'd0;
              pix_q         <= '0;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + CNT_W'(1);
              state_q       <= armEn ? HDR : IDLE;
            end else if (slot_q == 2'd2) begin
              slots_q <= '0;
              slot_q  <= 2'd0;
              pix_q   <= pix_inc_c;
            end else begin
              slots_q <= slots_c;
              slot_q  <= slot_q + 2'd1;
              pix_q   <= pix_inc_c;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spectro_word_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_c),
    .pop   (wordReady),
    .din   (push_word_c),
    .dout  (wordOut),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wordValid  = ~fifo_empty;
  assign frameDone  = frame_done_q;
  assign frameCount = frame_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spectro_frame_packer.sv
// Self-checking bench for spectro_frame_packer: table-driven sample vectors with a word scoreboard.
module tb_spectro_frame_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  sampleIn;
  logic        sampleValid;
  logic        armEn;
  logic        wordReady;

  logic [31:0] wo6, wo4;
  logic        wv6, wv4, fd6, fd4, ov6, ov4;
  logic [15:0] fc6, fc4;

  always #5 CLK = ~CLK;

  spectro_frame_packer #(.PIXELS_PER_FRAME(6), .OUT_DEPTH(4)) u_dut6 (
    .CLK(CLK), .RST(RST), .sampleIn(sampleIn), .sampleValid(sampleValid), .armEn(armEn),
    .wordOut(wo6), .wordValid(wv6), .wordReady(wordReady), .frameDone(fd6),
    .frameCount(fc6), .overflow(ov6)
  );

  spectro_frame_packer #(.PIXELS_PER_FRAME(4), .OUT_DEPTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .sampleIn(sampleIn), .sampleValid(sampleValid), .armEn(armEn),
    .wordOut(wo4), .wordValid(wv4), .wordReady(wordReady), .frameDone(fd4),
    .frameCount(fc4), .overflow(ov4)
  );

  typedef struct {
    logic        valid;
    logic [9:0]  sample;
    logic        exp_push;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs [32];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp6_q [$];
  logic [31:0] exp4_q [$];
  bit          mon6_en = 1'b0;
  bit          mon4_en = 1'b0;
  int          fd6_cnt = 0;
  int          fd4_cnt = 0;

  function automatic vec_t mk(input logic v, input logic [9:0] s, input logic p, input logic [31:0] w);
    vec_t r;
    r.valid = v; r.sample = s; r.exp_push = p; r.exp_word = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboards: every word leaving a DUT must match the head of its expected queue.
  always @(negedge CLK) begin
    if (fd6) fd6_cnt++;
    if (mon6_en && wv6 && wordReady) begin
      if (exp6_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb6_extra: got %h want none", wo6);
      end else check("sb6_word", wo6, exp6_q.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (fd4) fd4_cnt++;
    if (mon4_en && wv4 && wordReady) begin
      if (exp4_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb4_extra: got %h want none", wo4);
      end else check("sb4_word", wo4, exp4_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [31:0] w);
    if (sel == 6) exp6_q.push_back(w);
    else exp4_q.push_back(w);
  endtask

  task automatic do_reset();
    RST = 1'b1; armEn = 1'b0; sampleValid = 1'b0; sampleIn = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic arm(input int sel, input bit hold, input bit expect_hdr, input logic [31:0] hdr);
    armEn = 1'b1; sampleValid = 1'b0;
    tick();
    armEn = hold;
    if (expect_hdr) push_exp(sel, hdr);
    tick();
  endtask

  task automatic run_vecs(input int sel, input int first, input int n, input bit expect_words);
    for (int i = first; i < first + n; i++) begin
      sampleValid = vecs[i].valid;
      sampleIn    = vecs[i].sample;
      if (expect_words && vecs[i].exp_push) push_exp(sel, vecs[i].exp_word);
      tick();
    end
    sampleValid = 1'b0;
  endtask

  task automatic drain(input int sel, input string name);
    int n = 0;
    while (((sel == 6) ? exp6_q.size() : exp4_q.size()) != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'((sel == 6) ? exp6_q.size() : exp4_q.size()), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 6; k++)
      vecs[k] = mk(1'b1, 10'(k + 1), (k == 2 || k == 5),
                   (k == 2) ? 32'h40300801 : ((k == 5) ? 32'hC0601404 : 32'h0));
    for (int k = 0; k < 6; k++) begin
      vecs[6 + 3*k] = mk(1'b1, 10'(k + 1), (k == 2 || k == 5),
                         (k == 2) ? 32'h40300801 : ((k == 5) ? 32'hC0601404 : 32'h0));
      if (k < 5) begin
        vecs[7 + 3*k] = mk(1'b0, 10'h3FF, 1'b0, 32'h0);
        vecs[8 + 3*k] = mk(1'b0, 10'h3FF, 1'b0, 32'h0);
      end
    end
    for (int k = 0; k < 4; k++)
      vecs[22 + k] = mk(1'b1, 10'(k + 1), (k >= 2),
                        (k == 2) ? 32'h40300801 : ((k == 3) ? 32'hC0000004 : 32'h0));
    for (int k = 0; k < 6; k++)
      vecs[26 + k] = mk(1'b1, 10'(k + 7), (k == 2 || k == 5),
                        (k == 2) ? 32'h40902007 : ((k == 5) ? 32'hC0C02C0A : 32'h0));

    wordReady = 1'b1;
    do_reset();
    @(negedge CLK);
    check("rst_wordOut", wo6, 32'h0);
    check("rst_wordValid", 32'(wv6), 32'd0);
    check("rst_frameDone", 32'(fd6), 32'd0);
    check("rst_frameCount", 32'(fc6), 32'd0);
    check("rst_overflow", 32'(ov6), 32'd0);
    mon6_en = 1'b1;

    // Basic frame
    fd6_cnt = 0;
    arm(6, 1'b0, 1'b1, 32'hA55A0000);
    run_vecs(6, 0, 6, 1'b1);
    drain(6, "basic_drain");
    check("basic_frameDone_pulses", 32'(fd6_cnt), 32'd1);
    check("basic_frameCount", 32'(fc6), 32'd1);

    // Gapped input
    do_reset();
    fd6_cnt = 0;
    arm(6, 1'b0, 1'b1, 32'hA55A0000);
    run_vecs(6, 6, 16, 1'b1);
    drain(6, "gap_drain");
    check("gap_frameDone_pulses", 32'(fd6_cnt), 32'd1);
    check("gap_frameCount", 32'(fc6), 32'd1);

    // Partial last word on the 4-pixel instance
    mon6_en = 1'b0; mon4_en = 1'b1;
    do_reset();
    fd4_cnt = 0;
    arm(4, 1'b0, 1'b1, 32'hA55A0000);
    run_vecs(4, 22, 4, 1'b1);
    drain(4, "partial_drain");
    check("partial_frameDone_pulses", 32'(fd4_cnt), 32'd1);
    check("partial_frameCount", 32'(fc4), 32'd1);
    mon4_en = 1'b0;

    // Back-to-back frames; armEn drops at the start of frame 2 but it still completes
    do_reset();
    mon6_en = 1'b1;
    fd6_cnt = 0;
    arm(6, 1'b1, 1'b1, 32'hA55A0000);
    run_vecs(6, 0, 6, 1'b1);
    push_exp(6, 32'hA55A0001);
    armEn = 1'b0;
    @(negedge CLK);
    check("b2b_last_word", wo6, 32'hC0601404);
    check("b2b_frameDone", 32'(fd6), 32'd1);
    tick();
    @(negedge CLK);
    check("b2b_second_header", wo6, 32'hA55A0001);
    check("b2b_frameDone_low", 32'(fd6), 32'd0);
    run_vecs(6, 26, 6, 1'b1);
    drain(6, "b2b_drain");
    check("b2b_frameDone_pulses", 32'(fd6_cnt), 32'd2);
    check("b2b_frameCount", 32'(fc6), 32'd2);
    repeat (3) tick();
    check("b2b_stops_when_disarmed", 32'(wv6), 32'd0);

    // Overflow with the consumer stalled
    do_reset();
    wordReady = 1'b0;
    arm(6, 1'b1, 1'b1, 32'hA55A0000);
    run_vecs(6, 0, 6, 1'b1);
    push_exp(6, 32'hA55A0001);
    armEn = 1'b0;
    tick();
    run_vecs(6, 26, 6, 1'b0);
    @(negedge CLK);
    check("ovf_flag", 32'(ov6), 32'd1);
    check("ovf_wordValid", 32'(wv6), 32'd1);
    check("ovf_head", wo6, 32'hA55A0000);
    check("ovf_frameCount", 32'(fc6), 32'd2);
    tick();
    wordReady = 1'b1;
    drain(6, "ovf_drain");
    check("ovf_sticky", 32'(ov6), 32'd1);

    // Reset mid-frame with overflow and frameCount still set from above
    wordReady = 1'b0;
    arm(6, 1'b0, 1'b0, 32'h0);
    sampleValid = 1'b1; sampleIn = 10'd1;
    tick();
    sampleIn = 10'd2;
    tick();
    sampleValid = 1'b0;
    @(negedge CLK);
    check("mid_header_buffered", 32'(wv6), 32'd1);
    RST = 1'b1;
    tick();
    @(negedge CLK);
    check("mid_rst_wordOut", wo6, 32'h0);
    check("mid_rst_wordValid", 32'(wv6), 32'd0);
    check("mid_rst_frameDone", 32'(fd6), 32'd0);
    check("mid_rst_frameCount", 32'(fc6), 32'd0);
    check("mid_rst_overflow", 32'(ov6), 32'd0);
    RST = 1'b0;
    wordReady = 1'b1;
    tick();
    arm(6, 1'b0, 1'b1, 32'hA55A0000);
    run_vecs(6, 0, 6, 1'b1);
    drain(6, "rearm_drain");
    check("rearm_frameCount", 32'(fc6), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
